red_pitaya_rst_seq: RTL and testbench
=====================================

RED_PITAYA_RST_SEQ -- requirements
Module: red_pitaya_rst_seq

Interface
REQ-001 SHALL have parameter LOCK_FILT, default 1024: consecutive synchronized lock-high cycles required before the hold phase starts; legal range 1..65536.
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles of reset extension after lock is qualified; legal range 1..65536.
REQ-003 SHALL have parameter CW, default 16: width of the lock-loss event counter.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic is in this domain.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port pll_locked, input, 1 bit: PLL lock status, asynchronous to clk.
REQ-007 SHALL have port sw_rst, input, 1 bit: synchronous software re-sequence request, level-sampled each cycle.
REQ-008 SHALL have port lost_clr, input, 1 bit: synchronous clear of lost_cnt.
REQ-009 SHALL have port rst_out_n, output, 1 bit: active-low reset for downstream logic on the PLL clocks.
REQ-010 SHALL have port state, output, 2 bits: current FSM state (0=WAIT, 1=FILT, 2=HOLD, 3=RUN).
REQ-011 SHALL have port lost_cnt, output, CW bits: number of lock-loss events seen while in RUN.

Function
REQ-012 SHALL pass pll_locked through a 2-flop synchronizer; lock_s is the second-stage output.
REQ-013 SHALL implement a 4-state FSM, WAIT/FILT/HOLD/RUN, with one shared down-counter or up-counter wide enough for max(LOCK_FILT, HOLD_CYC).
REQ-014 In WAIT, the FSM SHALL go to FILT with the counter at 0 when lock_s=1; otherwise it SHALL stay in WAIT.
REQ-015 In FILT, with lock_s=1 and counter=LOCK_FILT-1, the FSM SHALL go to HOLD and clear the counter; with lock_s=1 and any other counter value, it SHALL increment the counter.
REQ-016 In HOLD, with counter=HOLD_CYC-1, the FSM SHALL go to RUN; otherwise it SHALL increment the counter.
REQ-017 In FILT, HOLD or RUN, lock_s=0 SHALL send the FSM to WAIT and clear the counter; this rule has highest priority over every other transition.
REQ-018 In RUN with lock_s=1, sw_rst=1 SHALL send the FSM to HOLD with the counter cleared.
REQ-019 In HOLD with lock_s=1, sw_rst=1 SHALL restart the hold: counter cleared, HOLD retained.
REQ-020 sw_rst SHALL be ignored in WAIT and FILT.
REQ-021 rst_out_n SHALL be 1 exactly when state=RUN, and SHALL be driven directly from a registered state bit with no combinational decode glitches.
REQ-022 With a constant pll_locked=1: counting the first clk edge that samples pll_locked=1 into the synchronizer as edge 0, state SHALL become RUN and rst_out_n SHALL become 1 immediately after edge LOCK_FILT+HOLD_CYC+2.
REQ-023 Lock loss in RUN: lost_cnt SHALL increment on the same edge as the RUN-to-WAIT transition; rst_out_n SHALL be 0 after that edge (latency from pll_locked fall: 3 edges).
REQ-024 lost_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-025 lost_clr=1 SHALL set lost_cnt to 0 on the next edge; if lost_clr and a lock-loss event occur on the same edge, lost_cnt SHALL become 1.
REQ-026 A lock drop in WAIT, FILT or HOLD SHALL NOT increment lost_cnt.
REQ-027 A sw_rst-driven RUN-to-HOLD transition SHALL NOT increment lost_cnt.

Reset
REQ-028 rst=1 SHALL immediately, asynchronously, force: both synchronizer flops 0, state=WAIT, counter 0, rst_out_n=0, lost_cnt=0.
REQ-029 After rst deasserts, the FSM SHALL restart from WAIT regardless of the pll_locked level; asserting rst mid-sequence or in RUN SHALL abort the sequence without incrementing lost_cnt.

Verification (LOCK_FILT=4, HOLD_CYC=3, CW=4)
REQ-030 Case: pll_locked held 1 from edge 0 -> state passes 1, 2, 3; rst_out_n rises after edge 9 and stays 1; lost_cnt=0.
REQ-031 Case: pll_locked high 3 cycles, then low 1 cycle, then high -> state returns to WAIT, the filter restarts, lost_cnt=0, and rst_out_n rises 9 edges after the re-rise.
REQ-032 Case: in RUN, pll_locked drops -> rst_out_n=0 after 3 edges, state=0, lost_cnt=1; relock gives RUN again after the full sequence.
REQ-033 Case: in RUN, a 1-cycle sw_rst pulse -> state=2 and rst_out_n=0 for exactly 3 cycles, then RUN; lost_cnt unchanged. A second pulse during HOLD extends HOLD by 3 cycles from that pulse.
REQ-034 Case: 17 lock-loss events -> lost_cnt=15 (saturated); lost_clr coincident with an 18th event -> lost_cnt=1.
REQ-035 Case: rst pulsed asynchronously, between clk edges, while in HOLD -> rst_out_n=0, state=0, lost_cnt=0 before the next clk edge; the sequence restarts after rst release.

Source files
------------

// File: rtl/red_pitaya_rst_seq.sv
// ---------------------------------------------------------------------------
// red_pitaya_rst_seq
// Reset sequencer for logic running on PLL-derived clocks. It synchronizes the
// PLL lock flag, waits for LOCK_FILT consecutive lock-high cycles, then holds
// the reset for a further HOLD_CYC cycles before releasing rst_out_n. Losing
// lock returns the sequencer to WAIT. A software request re-runs the hold.
// Lock losses seen while running are counted in a saturating counter.
//
// Ports:
//   clk        - system clock, the only clock domain
//   rst        - asynchronous active-high reset
//   pll_locked - PLL lock status, asynchronous to clk
//   sw_rst     - software re-sequence request, level-sampled (HOLD/RUN only)
//   lost_clr   - synchronous clear of lost_cnt
//   rst_out_n  - active-low downstream reset, high only in RUN
//   state      - current state: 0=WAIT, 1=FILT, 2=HOLD, 3=RUN
//   lost_cnt   - saturating count of lock-loss events seen while in RUN
// ---------------------------------------------------------------------------
module red_pitaya_rst_seq #(
  parameter int unsigned LOCK_FILT = 1024,
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          sw_rst,
  input  logic          lost_clr,
  output logic          rst_out_n,
  output logic [1:0]    state,
  output logic [CW-1:0] lost_cnt
);

  // One shared counter serves both the filter and the hold phase.
  localparam int unsigned CNT_MAX = (LOCK_FILT > HOLD_CYC) ? LOCK_FILT : HOLD_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CW-1:0]    LOST_MAX  = '1;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_FILT = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q;
  logic             lock_s;
  logic             lost_evt_c;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lock_s  <= sync1_q;
    end
  end

  // Next-state and counter logic; loss of lock overrides everything else.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    lost_evt_c = 1'b0;
    if ((st_q != S_WAIT) && !lock_s) begin
      st_d       = S_WAIT;
      cnt_d      = '0;
      lost_evt_c = (st_q == S_RUN);
    end else begin
      unique case (st_q)
        S_WAIT: begin
          if (lock_s) begin
            st_d  = S_FILT;
            cnt_d = '0;
          end
        end
        S_FILT: begin
          if (cnt_q == FILT_LAST) begin
            st_d  = S_HOLD;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (sw_rst) begin
            cnt_d = '0;
          end else if (cnt_q == HOLD_LAST) begin
            st_d  = S_RUN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (sw_rst) begin
            st_d  = S_HOLD;
            cnt_d = '0;
          end
        end
        default: begin
          st_d  = S_WAIT;
          cnt_d = '0;
        end
      endcase
    end
  end

  // State register; rst_out_n is its own flop so it cannot glitch on decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= S_WAIT;
      cnt_q     <= '0;
      rst_out_n <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      rst_out_n <= (st_d == S_RUN);
    end
  end

  // Lock-loss counter: saturates; a clear coinciding with an event yields 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_cnt <= '0;
    end else if (lost_clr) begin
      lost_cnt <= lost_evt_c ? CW'(1) : '0;
    end else if (lost_evt_c && (lost_cnt != LOST_MAX)) begin
      lost_cnt <= lost_cnt + CW'(1);
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_red_pitaya_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_red_pitaya_rst_seq
// Directed bench for red_pitaya_rst_seq with LOCK_FILT=4, HOLD_CYC=3, CW=4.
// Stimulus queues hand-computed expectations tagged with the clock edge after
// which they hold (or "now" for asynchronous checks); a monitor samples the
// outputs 1 time unit after each rising edge and retires matching entries.
// ---------------------------------------------------------------------------
module tb_red_pitaya_rst_seq;

  typedef struct {
    int         cyc;   // edge index after which this holds; -1 = immediate
    string      name;
    logic [1:0] st;
    logic [3:0] lc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       sw_rst;
  logic       lost_clr;
  logic       rst_out_n;
  logic [1:0] state;
  logic [3:0] lost_cnt;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic async_pulse;

  red_pitaya_rst_seq #(
    .LOCK_FILT (4),
    .HOLD_CYC  (3),
    .CW        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sw_rst     (sw_rst),
    .lost_clr   (lost_clr),
    .rst_out_n  (rst_out_n),
    .state      (state),
    .lost_cnt   (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    logic rn_exp;
    rn_exp = (e.st == 2'd3);
    n_cmp++;
    if (state !== e.st || rst_out_n !== rn_exp || lost_cnt !== e.lc) begin
      n_err++;
      $display("FAIL %s (edge %0d): got state=%0d rst_out_n=%0b lost_cnt=%0d, want state=%0d rst_out_n=%0b lost_cnt=%0d",
               e.name, cyc, state, rst_out_n, lost_cnt, e.st, rn_exp, e.lc);
    end
  endtask

  task automatic retire(input int c);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == c) begin
        compare(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc != -1 && sb[i].cyc < c) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: expectation for edge %0d never sampled (now %0d)", sb[i].name, sb[i].cyc, c);
        sb.delete(i);
      end
    end
  endtask

  // Monitor: checks after every rising edge, or immediately on request.
  initial begin
    forever begin
      @(posedge clk or posedge async_pulse);
      if (async_pulse) begin
        retire(-1);
      end else begin
        #1;
        cyc++;
        retire(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int k, input string nm, input logic [1:0] st, input logic [3:0] lc);
    exp_t e;
    e.cyc = cyc + k; e.name = nm; e.st = st; e.lc = lc;
    sb.push_back(e);
  endtask

  task automatic async_check(input string nm, input logic [1:0] st, input logic [3:0] lc);
    exp_t e;
    e.cyc = -1; e.name = nm; e.st = st; e.lc = lc;
    sb.push_back(e);
    async_pulse = 1'b1;
    #1;
    async_pulse = 1'b0;
  endtask

  initial begin
    logic [3:0] lc_prev;
    logic [3:0] lc_now;
    cyc = 0; n_cmp = 0; n_err = 0; async_pulse = 1'b0;
    rst = 1'b1; pll_locked = 1'b0; sw_rst = 1'b0; lost_clr = 1'b0;

    // Reset state, before and across clock edges.
    #2;
    async_check("reset_async", 2'd0, 4'd0);
    tick(2);
    expect_at(1, "reset_hold", 2'd0, 4'd0);
    rst = 1'b0;
    expect_at(2, "wait_no_lock", 2'd0, 4'd0);
    tick(3);

    // A: constant lock -> FILT, HOLD, RUN after edge 9.
    pll_locked = 1'b1;
    expect_at(2,  "a_wait_sync", 2'd0, 4'd0);
    expect_at(3,  "a_filt",      2'd1, 4'd0);
    expect_at(6,  "a_filt_last", 2'd1, 4'd0);
    expect_at(7,  "a_hold",      2'd2, 4'd0);
    expect_at(9,  "a_hold_last", 2'd2, 4'd0);
    expect_at(10, "a_run",       2'd3, 4'd0);
    expect_at(14, "a_run_stays", 2'd3, 4'd0);
    tick(15);

    // B: lock loss in RUN, then relock.
    pll_locked = 1'b0;
    expect_at(2, "b_still_run", 2'd3, 4'd0);
    expect_at(3, "b_wait",      2'd0, 4'd1);
    tick(5);
    pll_locked = 1'b1;
    expect_at(9,  "b_relock_hold", 2'd2, 4'd1);
    expect_at(10, "b_relock_run",  2'd3, 4'd1);
    tick(12);

    // C: sw_rst pulse in RUN, then a second pulse extending HOLD.
    sw_rst = 1'b1;
    expect_at(1, "c_hold_first", 2'd2, 4'd1);
    expect_at(3, "c_hold_last",  2'd2, 4'd1);
    expect_at(4, "c_run",        2'd3, 4'd1);
    tick(1);
    sw_rst = 1'b0;
    tick(5);
    sw_rst = 1'b1;
    expect_at(1, "c2_hold",      2'd2, 4'd1);
    expect_at(4, "c2_extended",  2'd2, 4'd1);
    expect_at(5, "c2_hold_last", 2'd2, 4'd1);
    expect_at(6, "c2_run",       2'd3, 4'd1);
    tick(1);
    sw_rst = 1'b0;
    tick(1);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(6);

    // D: drop from RUN, then a 1-cycle lock glitch during FILT (sw_rst ignored).
    pll_locked = 1'b0;
    expect_at(3, "d_loss", 2'd0, 4'd2);
    tick(6);
    pll_locked = 1'b1;
    sw_rst     = 1'b1;
    expect_at(3,  "d_filt",     2'd1, 4'd2);
    expect_at(5,  "d_filt2",    2'd1, 4'd2);
    expect_at(6,  "d_wait",     2'd0, 4'd2);
    expect_at(7,  "d_refilt",   2'd1, 4'd2);
    expect_at(10, "d_filt_end", 2'd1, 4'd2);
    expect_at(11, "d_hold",     2'd2, 4'd2);
    expect_at(14, "d_run",      2'd3, 4'd2);
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    sw_rst     = 1'b0;
    tick(11);

    // E: asynchronous reset between edges while in HOLD.
    sw_rst = 1'b1;
    expect_at(1, "e_hold", 2'd2, 4'd2);
    tick(1);
    sw_rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    async_check("e_async_rst", 2'd0, 4'd0);
    @(negedge clk);
    expect_at(1,  "e_wait_after", 2'd0, 4'd0);
    expect_at(9,  "e_hold_again", 2'd2, 4'd0);
    expect_at(10, "e_run",        2'd3, 4'd0);
    rst = 1'b0;
    tick(12);

    // F: 17 lock losses saturate, then clear coincident with an 18th.
    for (int i = 1; i <= 17; i++) begin
      lc_prev = (i - 1 > 15) ? 4'd15 : 4'(i - 1);
      lc_now  = (i > 15) ? 4'd15 : 4'(i);
      pll_locked = 1'b1;
      expect_at(10, "f_run", 2'd3, lc_prev);
      tick(11);
      pll_locked = 1'b0;
      expect_at(3, "f_loss", 2'd0, lc_now);
      tick(4);
    end
    pll_locked = 1'b1;
    expect_at(10, "f_run_sat", 2'd3, 4'd15);
    tick(11);
    pll_locked = 1'b0;
    expect_at(3, "f_clr_evt", 2'd0, 4'd1);
    tick(2);
    lost_clr = 1'b1;
    tick(1);
    lost_clr = 1'b0;
    tick(1);
    lost_clr = 1'b1;
    expect_at(1, "f_clr_only", 2'd0, 4'd0);
    tick(1);
    lost_clr = 1'b0;
    tick(2);

    // Drain: anything still queued is a missed check.
    repeat (50) if (sb.size() != 0) @(negedge clk);
    while (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: expectation never retired", sb[0].name);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
